// File: rtl/countdown_timer_bcd_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_bcd_if
// Command and status bundle of the countdown timer core.
//   master : drives the command pulses and presets, observes the count/flags
//            (control logic or a testbench).
//   slave  : the timer core itself.
// Signals:
//   start, pause, clear, load : one-cycle command pulses
//   preset_min, preset_sec    : BCD preset copied into the count on load
//   min_bcd, sec_bcd          : current count, BCD
//   running                   : high while counting down
//   done                      : one-cycle pulse when the count reaches 00:00
//   alarm                     : 2 Hz square wave while the alarm sounds
//   tick_1hz                  : one-cycle pulse after each decrement
// -----------------------------------------------------------------------------
interface countdown_timer_bcd_if;
    logic       start;
    logic       pause;
    logic       clear;
    logic       load;
    logic [7:0] preset_min;
    logic [7:0] preset_sec;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       done;
    logic       alarm;
    logic       tick_1hz;

    modport master (
        output start, pause, clear, load, preset_min, preset_sec,
        input  min_bcd, sec_bcd, running, done, alarm, tick_1hz
    );

    modport slave (
        input  start, pause, clear, load, preset_min, preset_sec,
        output min_bcd, sec_bcd, running, done, alarm, tick_1hz
    );
endinterface

// File: rtl/countdown_timer_bcd.sv
// -----------------------------------------------------------------------------
// countdown_timer_bcd
// MM:SS countdown timer in BCD. The 512 Hz divider output is synchronised
// into clk, turned into one-cycle ticks, and prescaled to a 1 Hz step.
// On reaching 00:00 the core raises a 2 Hz alarm for ALARM_SEC seconds.
// Parameters:
//   TICKS_PER_SEC : clk_512 rising edges per second (multiple of 4, >= 4)
//   ALARM_SEC     : alarm duration in seconds (1..15)
// Ports:
//   clk     : system clock, all logic on its rising edge
//   rst_n   : asynchronous active-low reset
//   clk_512 : divider square wave, sampled as asynchronous data
//   bus     : command/status bundle (slave side)
// -----------------------------------------------------------------------------
module countdown_timer_bcd #(
    parameter int TICKS_PER_SEC = 512,
    parameter int ALARM_SEC     = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_512,
    countdown_timer_bcd_if.slave   bus
);
    localparam int              PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0]   Q1         = PW'(TICKS_PER_SEC / 4);
    localparam logic [PW-1:0]   Q2         = PW'(TICKS_PER_SEC / 2);
    localparam logic [PW-1:0]   Q3         = PW'((3 * TICKS_PER_SEC) / 4);
    localparam logic [3:0]      ALARM_LAST = 4'(ALARM_SEC - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, sync3_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    min_q, min_d;
    logic [7:0]    sec_q, sec_d;
    logic [3:0]    alarm_secs_q, alarm_secs_d;
    logic          alarm_q, alarm_d;
    logic          done_q, done_d;
    logic          tick_q, tick_d;

    logic          tick512;
    logic          counting;
    logic          sec_tick;
    logic          count_zero;
    logic          preset_ok;
    logic [15:0]   dec_count;

    // Saturating BCD decrement of MM:SS; 00:00 stays 00:00.
    function automatic logic [15:0] bcd_decrement(input logic [7:0] m, input logic [7:0] s);
        logic [7:0] m_n;
        logic [7:0] s_n;
        m_n = m;
        s_n = s;
        if (s[3:0] != 4'd0) begin
            s_n[3:0] = s[3:0] - 4'd1;
        end else if (s[7:4] != 4'd0) begin
            s_n = {s[7:4] - 4'd1, 4'd9};
        end else if (m != 8'h00) begin
            s_n = 8'h59;
            if (m[3:0] != 4'd0) begin
                m_n[3:0] = m[3:0] - 4'd1;
            end else begin
                m_n = {m[7:4] - 4'd1, 4'd9};
            end
        end
        return {m_n, s_n};
    endfunction

    assign tick512    = sync2_q & ~sync3_q;
    assign counting   = (state_q == RUN) || (state_q == ALARM);
    assign sec_tick   = tick512 && counting && (presc_q == PRESC_MAX);
    assign count_zero = (min_q == 8'h00) && (sec_q == 8'h00);
    assign dec_count  = bcd_decrement(min_q, sec_q);
    assign preset_ok  = (bus.preset_min[7:4] <= 4'd9) && (bus.preset_min[3:0] <= 4'd9) &&
                        (bus.preset_sec[7:4] <= 4'd5) && (bus.preset_sec[3:0] <= 4'd9);

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        min_d        = min_q;
        sec_d        = sec_q;
        alarm_secs_d = alarm_secs_q;
        done_d       = 1'b0;
        tick_d       = 1'b0;

        if (counting && tick512) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        end

        if (bus.clear) begin
            // Clear overrides everything, including a coincident second tick.
            state_d = IDLE;
            presc_d = '0;
            min_d   = 8'h00;
            sec_d   = 8'h00;
        end else begin
            case (state_q)
                RUN: begin
                    if (sec_tick) begin
                        min_d  = dec_count[15:8];
                        sec_d  = dec_count[7:0];
                        tick_d = 1'b1;
                        if (dec_count == 16'h0000) begin
                            done_d       = 1'b1;
                            state_d      = ALARM;
                            presc_d      = '0;
                            alarm_secs_d = 4'd0;
                        end
                    end
                end
                ALARM: begin
                    if (sec_tick) begin
                        if (alarm_secs_q == ALARM_LAST) begin
                            state_d = IDLE;
                        end else begin
                            alarm_secs_d = alarm_secs_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase

            // Only the highest-priority asserted command is considered, even
            // when that command turns out to be ignored in the current state.
            if (bus.load) begin
                if (((state_q == IDLE) || (state_q == PAUSE)) && preset_ok) begin
                    min_d = bus.preset_min;
                    sec_d = bus.preset_sec;
                end
            end else if (bus.start) begin
                if ((state_q == IDLE) && !count_zero) begin
                    state_d = RUN;
                    presc_d = '0;
                end else if (state_q == PAUSE) begin
                    state_d = RUN;
                end
            end else if (bus.pause) begin
                // Reaching 00:00 on the same cycle takes precedence over pause.
                if ((state_q == RUN) && (state_d == RUN)) begin
                    state_d = PAUSE;
                end
            end
        end

        // First quarter and third quarter of each second are high: 2 Hz,
        // starting high because the prescaler is zeroed on ALARM entry.
        alarm_d = (state_d == ALARM) &&
                  ((presc_d < Q1) || ((presc_d >= Q2) && (presc_d < Q3)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            presc_q      <= '0;
            min_q        <= 8'h00;
            sec_q        <= 8'h00;
            alarm_secs_q <= 4'd0;
            alarm_q      <= 1'b0;
            done_q       <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= clk_512;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            presc_q      <= presc_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            alarm_secs_q <= alarm_secs_d;
            alarm_q      <= alarm_d;
            done_q       <= done_d;
            tick_q       <= tick_d;
        end
    end

    assign bus.min_bcd  = min_q;
    assign bus.sec_bcd  = sec_q;
    assign bus.running  = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.alarm    = alarm_q;
    assign bus.tick_1hz = tick_q;
endmodule

// File: tb/tb_countdown_timer_bcd.sv
module tb_countdown_timer_bcd;
    localparam int TPS  = 8;
    localparam int ASEC = 3;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic clk_512 = 1'b0;

    countdown_timer_bcd_if bus();

    countdown_timer_bcd #(
        .TICKS_PER_SEC (TPS),
        .ALARM_SEC     (ASEC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_512 (clk_512),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int passed   = 0;
    int done_cnt = 0;
    int tick_cnt = 0;

    always @(negedge clk) begin
        if (bus.done === 1'b1)     done_cnt++;
        if (bus.tick_1hz === 1'b1) tick_cnt++;
    end

    // n full periods of clk_512 (4 clk high, 4 clk low); each yields one tick512
    task automatic tick(input int n);
        repeat (n) begin
            clk_512 = 1'b1;
            repeat (4) @(negedge clk);
            clk_512 = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    // 0 start, 1 pause, 2 clear
    task automatic cmd(input int which);
        case (which)
            0: bus.start = 1'b1;
            1: bus.pause = 1'b1;
            default: bus.clear = 1'b1;
        endcase
        @(negedge clk);
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.clear = 1'b0;
        $display("cmd %0d -> %h:%h running=%b alarm=%b", which, bus.min_bcd, bus.sec_bcd, bus.running, bus.alarm);
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        bus.preset_min = m;
        bus.preset_sec = s;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        $display("load %h:%h -> %h:%h", m, s, bus.min_bcd, bus.sec_bcd);
    endtask

    // One clk_512 period with a command placed on the exact tick512 cycle
    task automatic aligned_cmd(input bit use_clear);
        clk_512 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (use_clear) bus.clear = 1'b1; else bus.pause = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.pause = 1'b0;
        @(negedge clk);
        clk_512 = 1'b0;
        repeat (4) @(negedge clk);
        $display("aligned %s -> %h:%h running=%b", use_clear ? "clear" : "pause", bus.min_bcd, bus.sec_bcd, bus.running);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.min_bcd !== 8'h00) $display("FAIL rst_min: got %h expected 00", bus.min_bcd); else passed++;
        checks++; if (bus.sec_bcd !== 8'h00) $display("FAIL rst_sec: got %h expected 00", bus.sec_bcd); else passed++;
        checks++; if (bus.running !== 1'b0) $display("FAIL rst_running: got %b expected 0", bus.running); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b expected 0", bus.done); else passed++;
        checks++; if (bus.alarm !== 1'b0) $display("FAIL rst_alarm: got %b expected 0", bus.alarm); else passed++;
        checks++; if (bus.tick_1hz !== 1'b0) $display("FAIL rst_tick: got %b expected 0", bus.tick_1hz); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_countdown_alarm();
        done_cnt = 0;
        tick_cnt = 0;
        do_load(8'h00, 8'h03);
        checks++; if (bus.sec_bcd !== 8'h03) $display("FAIL load_0003: got %h expected 03", bus.sec_bcd); else passed++;
        cmd(0);
        checks++; if (bus.running !== 1'b1) $display("FAIL start_running: got %b expected 1", bus.running); else passed++;
        tick(8);
        checks++; if (bus.sec_bcd !== 8'h02) $display("FAIL first_dec: got %h expected 02", bus.sec_bcd); else passed++;
        checks++; if (tick_cnt !== 1) $display("FAIL tick_1hz_count1: got %0d expected 1", tick_cnt); else passed++;
        tick(16);
        checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0000) $display("FAIL reach_zero: got %h expected 0000", {bus.min_bcd, bus.sec_bcd}); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL done_once: got %0d expected 1", done_cnt); else passed++;
        checks++; if (bus.running !== 1'b0) $display("FAIL alarm_not_running: got %b expected 0", bus.running); else passed++;
        checks++; if (bus.alarm !== 1'b1) $display("FAIL alarm_k0: got %b expected 1", bus.alarm); else passed++;
        tick(1);
        checks++; if (bus.alarm !== 1'b1) $display("FAIL alarm_k1: got %b expected 1", bus.alarm); else passed++;
        tick(1);
        checks++; if (bus.alarm !== 1'b0) $display("FAIL alarm_k2: got %b expected 0", bus.alarm); else passed++;
        tick(2);
        checks++; if (bus.alarm !== 1'b1) $display("FAIL alarm_k4: got %b expected 1", bus.alarm); else passed++;
        tick(16);
        checks++; if (bus.alarm !== 1'b1) $display("FAIL alarm_k20: got %b expected 1", bus.alarm); else passed++;
        tick(4);
        checks++; if (bus.alarm !== 1'b0) $display("FAIL alarm_end_k24: got %b expected 0", bus.alarm); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL done_still_once: got %0d expected 1", done_cnt); else passed++;
        checks++; if (tick_cnt !== 3) $display("FAIL tick_1hz_count3: got %0d expected 3", tick_cnt); else passed++;
    endtask

    task automatic test_borrow();
        do_load(8'h01, 8'h00);
        cmd(0);
        tick(8);
        checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0059) $display("FAIL borrow_0100: got %h expected 0059", {bus.min_bcd, bus.sec_bcd}); else passed++;
        cmd(2);
        do_load(8'h10, 8'h00);
        cmd(0);
        tick(8);
        checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0959) $display("FAIL borrow_1000: got %h expected 0959", {bus.min_bcd, bus.sec_bcd}); else passed++;
        cmd(2);
        do_load(8'h00, 8'h20);
        cmd(0);
        tick(8);
        checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0019) $display("FAIL borrow_0020: got %h expected 0019", {bus.min_bcd, bus.sec_bcd}); else passed++;
        cmd(2);
        checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0000) $display("FAIL clear_run: got %h expected 0000", {bus.min_bcd, bus.sec_bcd}); else passed++;
    endtask

    task automatic test_pause();
        tick_cnt = 0;
        do_load(8'h00, 8'h10);
        cmd(0);
        tick(5);
        cmd(1);
        checks++; if (bus.running !== 1'b0) $display("FAIL pause_running: got %b expected 0", bus.running); else passed++;
        tick(20);
        checks++; if (bus.sec_bcd !== 8'h10) $display("FAIL pause_hold: got %h expected 10", bus.sec_bcd); else passed++;
        checks++; if (tick_cnt !== 0) $display("FAIL pause_no_tick: got %0d expected 0", tick_cnt); else passed++;
        cmd(0);
        checks++; if (bus.running !== 1'b1) $display("FAIL resume_running: got %b expected 1", bus.running); else passed++;
        tick(2);
        checks++; if (bus.sec_bcd !== 8'h10) $display("FAIL resume_2ticks: got %h expected 10", bus.sec_bcd); else passed++;
        tick(1);
        checks++; if (bus.sec_bcd !== 8'h09) $display("FAIL resume_3ticks: got %h expected 09", bus.sec_bcd); else passed++;
        cmd(2);
    endtask

    task automatic test_commands();
        cmd(0);
        checks++; if (bus.running !== 1'b0) $display("FAIL start_at_zero: got %b expected 0", bus.running); else passed++;
        do_load(8'h00, 8'h07);
        do_load(8'h00, 8'h5A);
        checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0007) $display("FAIL load_bad_sec: got %h expected 0007", {bus.min_bcd, bus.sec_bcd}); else passed++;
        do_load(8'hA0, 8'h00);
        checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0007) $display("FAIL load_bad_min: got %h expected 0007", {bus.min_bcd, bus.sec_bcd}); else passed++;
        do_load(8'h00, 8'h65);
        checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0007) $display("FAIL load_bad_tens: got %h expected 0007", {bus.min_bcd, bus.sec_bcd}); else passed++;
        // load and start together: load wins, start does not act
        bus.preset_min = 8'h00;
        bus.preset_sec = 8'h12;
        bus.load  = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        $display("load+start 00:12 -> %h:%h running=%b", bus.min_bcd, bus.sec_bcd, bus.running);
        checks++; if (bus.sec_bcd !== 8'h12) $display("FAIL prio_load_val: got %h expected 12", bus.sec_bcd); else passed++;
        checks++; if (bus.running !== 1'b0) $display("FAIL prio_load_state: got %b expected 0", bus.running); else passed++;
        cmd(0);
        do_load(8'h00, 8'h30);
        checks++; if (bus.sec_bcd !== 8'h12) $display("FAIL load_in_run: got %h expected 12", bus.sec_bcd); else passed++;
        checks++; if (bus.running !== 1'b1) $display("FAIL load_in_run_state: got %b expected 1", bus.running); else passed++;
        cmd(2);
    endtask

    task automatic test_clear_alarm();
        done_cnt = 0;
        do_load(8'h00, 8'h01);
        cmd(0);
        tick(8);
        checks++; if (bus.alarm !== 1'b1) $display("FAIL alarm_before_clear: got %b expected 1", bus.alarm); else passed++;
        checks++; if (done_cnt !== 1) $display("FAIL done_0001: got %0d expected 1", done_cnt); else passed++;
        cmd(2);
        checks++; if (bus.alarm !== 1'b0) $display("FAIL alarm_after_clear: got %b expected 0", bus.alarm); else passed++;
        tick(4);
        checks++; if (bus.alarm !== 1'b0) $display("FAIL alarm_stays_off: got %b expected 0", bus.alarm); else passed++;
    endtask

    task automatic test_simultaneous();
        done_cnt = 0;
        tick_cnt = 0;
        do_load(8'h00, 8'h05);
        cmd(0);
        tick(7);
        aligned_cmd(1'b0);
        checks++; if (bus.sec_bcd !== 8'h04) $display("FAIL pause_with_tick_dec: got %h expected 04", bus.sec_bcd); else passed++;
        checks++; if (bus.running !== 1'b0) $display("FAIL pause_with_tick_state: got %b expected 0", bus.running); else passed++;
        cmd(0);
        tick(7);
        checks++; if (bus.sec_bcd !== 8'h04) $display("FAIL pre_clear_hold: got %h expected 04", bus.sec_bcd); else passed++;
        aligned_cmd(1'b1);
        checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0000) $display("FAIL clear_with_tick_count: got %h expected 0000", {bus.min_bcd, bus.sec_bcd}); else passed++;
        checks++; if (done_cnt !== 0) $display("FAIL clear_with_tick_done: got %0d expected 0", done_cnt); else passed++;
        checks++; if (tick_cnt !== 1) $display("FAIL clear_with_tick_tick: got %0d expected 1", tick_cnt); else passed++;
        checks++; if (bus.running !== 1'b0) $display("FAIL clear_with_tick_state: got %b expected 0", bus.running); else passed++;
    endtask

    task automatic test_async_reset();
        do_load(8'h00, 8'h42);
        cmd(0);
        tick(3);
        checks++; if (bus.sec_bcd !== 8'h42) $display("FAIL pre_reset_count: got %h expected 42", bus.sec_bcd); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.min_bcd, bus.sec_bcd} !== 16'h0000) $display("FAIL async_rst_count: got %h expected 0000", {bus.min_bcd, bus.sec_bcd}); else passed++;
        checks++; if ({bus.running, bus.done, bus.alarm, bus.tick_1hz} !== 4'b0000) $display("FAIL async_rst_flags: got %b expected 0000", {bus.running, bus.done, bus.alarm, bus.tick_1hz}); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tick_cnt = 0;
        repeat (40) @(negedge clk);
        checks++; if (bus.running !== 1'b0) $display("FAIL post_rst_idle: got %b expected 0", bus.running); else passed++;
        do_load(8'h00, 8'h42);
        cmd(0);
        repeat (40) @(negedge clk);
        checks++; if (bus.sec_bcd !== 8'h42) $display("FAIL static_clk512: got %h expected 42", bus.sec_bcd); else passed++;
        checks++; if (tick_cnt !== 0) $display("FAIL static_no_tick: got %0d expected 0", tick_cnt); else passed++;
        cmd(2);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.clear      = 1'b0;
        bus.load       = 1'b0;
        bus.preset_min = 8'h00;
        bus.preset_sec = 8'h00;
        test_reset();
        test_countdown_alarm();
        test_borrow();
        test_pause();
        test_commands();
        test_clear_alarm();
        test_simultaneous();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/countdown_timer_bcd.md
# countdown_timer_bcd

Countdown timer core for the PengTimer design, directly downstream of the 512 Hz clock divider. It samples the divider's 512 Hz output in the system clock domain and derives a 1 Hz count enable from it. It decrements a preset MM:SS value in BCD and raises a timed alarm at zero. Its BCD outputs feed the display driver; its alarm output feeds the buzzer.

## Interface
- TICKS_PER_SEC, 512: clk_512 rising edges per second; multiple of 4, ≥4. Benches use 8.
- ALARM_SEC, 3: alarm duration in seconds after reaching 00:00; range 1–15.
- clk  in  1  system clock, 100 MHz; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low; clock clk.
- clk_512  in  1  512 Hz square wave from the divider; treated as asynchronous data and never used as a clock.
- start  in  1  one-cycle command pulse, already debounced.
- pause  in  1  one-cycle command pulse.
- clear  in  1  one-cycle command pulse.
- load  in  1  one-cycle command pulse: copy the preset into the count.
- preset_min  in  8  BCD minutes, 00–99.
- preset_sec  in  8  BCD seconds, 00–59.
- min_bcd  out  8  current minutes, BCD.
- sec_bcd  out  8  current seconds, BCD.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse when the count reaches 00:00.
- alarm  out  1  2 Hz square wave while in ALARM, else 0.
- tick_1hz  out  1  one-cycle pulse after each decrement.

## Operation
- Tick recovery: clk_512 passes through a 2-flop synchronizer, then an edge register. tick512 = s2 & ~s3.
- Prescaler: 0..TICKS_PER_SEC-1.
  - Advances on tick512 only in RUN and ALARM.
  - Holds in PAUSE and is zeroed on entry to RUN from IDLE, on entry to ALARM, and on clear.
  - A wrap from TICKS_PER_SEC-1 to 0 is the second tick (sec_tick).
- FSM states: IDLE, RUN, PAUSE, ALARM.
- Command priority: clear > load > start > pause. Only the highest-priority asserted command acts.
- Transitions:
  - IDLE + start with count ≠ 00:00 → RUN. With count = 00:00, start is ignored.
  - RUN + pause → PAUSE.
  - PAUSE + start → RUN, prescaler resumes from its held value.
  - RUN + sec_tick with count = 00:01 → count 00:00, done, ALARM.
  - ALARM after ALARM_SEC sec_ticks → IDLE.
  - Any state + clear → IDLE, count 00:00, alarm 0.
- load:
  - Acts only in IDLE or PAUSE; ignored in RUN and ALARM.
  - Ignored entirely if any preset digit is invalid: minute digit > 9, seconds tens > 5, or seconds ones > 9.
  - Does not change state.
- Decrement on sec_tick in RUN:
  - sec ones 0 borrows from sec tens.
  - sec 00 becomes 59 and borrows from minutes.
  - min ones 0 borrows from min tens.
  - The count never wraps below 00:00.
- Alarm:
  - Toggles every TICKS_PER_SEC/4 tick512 pulses, giving a 2 Hz square wave.
  - Starts high on the cycle after ALARM entry.

## Timing
- Reset values: min_bcd 00, sec_bcd 00, running 0, done 0, alarm 0, tick_1hz 0; state IDLE; prescaler 0; synchronizer flops 0.
- Tick latency: a clk_512 rising edge produces tick512 2–3 clk cycles later, depending on where the edge falls relative to clk, for exactly one cycle.
- The count updates on the clk edge that ends the sec_tick cycle.
- tick_1hz and done are registered and high for the following single cycle.
- running changes on the same edge as the state register.
- A command takes effect on the edge where its pulse is sampled; state and outputs reflect it the next cycle.
- First decrement after start from IDLE occurs on the TICKS_PER_SEC-th tick512 after start.
- Simultaneous pause and sec_tick in RUN: the decrement happens and the state becomes PAUSE.
- Simultaneous clear and sec_tick: clear wins, with no decrement and no done.
- rst_n asserted mid-run: all outputs go to reset values immediately (asynchronously). After release, the state is IDLE.

## Test plan
- TICKS_PER_SEC=8: load 00:03, then start → after 24 tick512, done pulses once, count 00:00, alarm toggles every 2 ticks, IDLE after 3×8 further ticks.
- Load 01:00, start, one second elapses → 00:59. Load 10:00 → 09:59 after one second.
- Pause after 5 of 8 ticks, hold 20 ticks, start → next decrement 3 ticks later.
- Count 00:00, start → stays IDLE, running 0. Load with preset_sec = 0x5A → count unchanged.
- clear asserted during ALARM → alarm 0 and IDLE next cycle. clear in the same cycle as sec_tick → no done.
- rst_n low mid-RUN at 00:42 → outputs 00:00 with all flags 0; clk_512 held static → no ticks.
